btn_event_decoder: RTL

Converts a single debounced, synchronous button level into one-cycle event pulses: short press, long press, auto-repeat while held, and (optionally) double click. Sits directly downstream of the per-button debounce stage, with one instance per button, and feeds the control/mode FSMs so they never deal with raw button levels or hold timing.

---
 rtl/btn_event_decoder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced button level into short/long/repeat/double-click pulses
// Define BTN_DCLICK_EN to compile in double-click detection (GAP/DHOLD states).
module btn_event_decoder #(
  parameter int P_CLK_HZ    = 100000000,
  parameter int P_LONG_MS   = 1000,
  parameter int P_REPEAT_MS = 200,
  parameter int P_DCLICK_MS = 300
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iBtn,
  output logic oHeld,
  output logic oShortPress,
  output logic oLongPress,
  output logic oRepeat,
  output logic oDoubleClick
);
  localparam int CPM      = P_CLK_HZ / 1000;
  localparam int LONG_CYC = CPM * P_LONG_MS;
  localparam int REP_CYC  = CPM * P_REPEAT_MS;
`ifdef BTN_DCLICK_EN
  localparam int GAP_CYC  = CPM * P_DCLICK_MS;
  localparam int MAX_LR   = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int MAX_CYC  = (MAX_LR > GAP_CYC) ? MAX_LR : GAP_CYC;
`else
  localparam int MAX_CYC  = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
`endif
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REP_CYC - 1);
`ifdef BTN_DCLICK_EN
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYC - 1);
`endif
  localparam logic [2:0] S_LOCK  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_PRESS = 3'd2;
  localparam logic [2:0] S_LONG  = 3'd3;
`ifdef BTN_DCLICK_EN
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DHOLD = 3'd5;
`endif

  if (P_LONG_MS < 1 || P_REPEAT_MS < 1 || P_DCLICK_MS < 1 || CPM < 1) begin : g_param_err
    $error("btn_event_decoder: timing parameters must be >= 1");
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_q, held_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
`ifdef BTN_DCLICK_EN
  logic          dclick_q, dclick_d;
`endif

  // Next state, hold counter and the single event pulse due at the next edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
`ifdef BTN_DCLICK_EN
    dclick_d = 1'b0;
`endif
    case (state_q)
      S_LOCK: state_d = iBtn ? S_LOCK : S_IDLE;
      S_IDLE: state_d = iBtn ? S_PRESS : S_IDLE;
      S_PRESS:
        if (cnt_q == LONG_END) begin
          long_d  = 1'b1;
          state_d = iBtn ? S_LONG : S_IDLE;
        end else if (!iBtn) begin
`ifdef BTN_DCLICK_EN
          state_d = S_GAP;
`else
          short_d = 1'b1;
          state_d = S_IDLE;
`endif
        end else cnt_d = cnt_q + CW'(1);
      S_LONG:
        if (!iBtn) state_d = S_IDLE;
        else if (cnt_q == REP_END) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else cnt_d = cnt_q + CW'(1);
`ifdef BTN_DCLICK_EN
      S_GAP:
        if (cnt_q == GAP_END) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end else if (iBtn) begin
          dclick_d = 1'b1;
          state_d  = S_DHOLD;
        end else cnt_d = cnt_q + CW'(1);
      S_DHOLD: state_d = iBtn ? S_DHOLD : S_IDLE;
`endif
      default: state_d = S_LOCK;
    endcase
    if (state_d != state_q) cnt_d = '0;
    held_d = (state_d == S_PRESS) || (state_d == S_LONG);
`ifdef BTN_DCLICK_EN
    held_d = held_d || (state_d == S_DHOLD);
`endif
  end

  // State, counter and registered outputs; reset drops any pending pulse
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= S_LOCK;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
`ifdef BTN_DCLICK_EN
      dclick_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
`ifdef BTN_DCLICK_EN
      dclick_q <= dclick_d;
`endif
    end
  end

  assign oHeld       = held_q;
  assign oShortPress = short_q;
  assign oLongPress  = long_q;
  assign oRepeat     = rep_q;
`ifdef BTN_DCLICK_EN
  assign oDoubleClick = dclick_q;
`else
  assign oDoubleClick = 1'b0;
`endif
endmodule
